// File: rtl/uart_rx16_pkg.sv
// uart_rx16_pkg
//   Shared UART definitions: receiver state encoding, default bit timing and
//   a helper that sizes the bit/gap timers. Also used by the transmitter.
package uart_rx16_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_GAP   = 3'd4
  } rx_state_e;

  localparam int unsigned UART_CLKS_PER_BIT = 100;
  localparam int unsigned UART_GAP_BITS     = 4;

  // One spare bit above the longest span timed, so no timer can wrap.
  function automatic int cnt_width(input int unsigned span);
    return $clog2(span) + 1;
  endfunction

endpackage

// File: rtl/uart_rx16_sync_2ff.sv
// sync_2ff
//   Two-flop synchronizer for an asynchronous, idle-high serial input.
//   Both flops reset to 1 so a reset line looks idle to downstream logic.
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous active-low reset
//   d_i     asynchronous input
//   q_o     synchronized output
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx16.sv
// uart_rx16
//   8N1 UART receiver assembling two consecutive bytes into a 16-bit word
//   (byte 0 -> [7:0], byte 1 -> [15:8]). Byte 1 must start within GAP_BITS
//   bit periods of byte 0's stop bit, otherwise the partial word is dropped.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | line idle, waiting for a falling edge (byte 0 expected)
//   START | timing to mid start bit; line high there is a glitch
//   DATA  | sampling 8 data bits at mid-bit, LSB first
//   STOP  | sampling stop bit at mid-bit
//   GAP   | byte 0 done, waiting for byte 1 start edge or timeout
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   rx_in      serial line, idle high
//   rx_data    last complete word
//   rx_valid   one-cycle pulse, rx_data updated
//   frame_err  one-cycle pulse, stop bit sampled low
//   gap_err    one-cycle pulse, byte 1 did not start in time
//   busy       high whenever not IDLE
module uart_rx16
  import uart_rx16_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int unsigned GAP_BITS     = UART_GAP_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_in,
  output logic [15:0] rx_data,
  output logic        rx_valid,
  output logic        frame_err,
  output logic        gap_err,
  output logic        busy
);

  localparam int CNT_W = cnt_width(GAP_BITS * CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] GAP_M1  = CNT_W'(GAP_BITS * CLKS_PER_BIT - 1);

  logic rxs;
  logic rxs_prev_q;
  logic fall;

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic             byte_idx_q, byte_idx_d;
  logic [15:0]      shadow_q, shadow_d;
  logic [15:0]      rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             gap_err_q, gap_err_d;

  sync_2ff u_sync (
    .clk_i  (clk),
    .rst_ni (rst),
    .d_i    (rx_in),
    .q_o    (rxs)
  );

  // Edge detect needs the line seen high first, so after a low stop bit
  // IDLE naturally waits for the line to return high.
  assign fall = rxs_prev_q & ~rxs;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxs_prev_q  <= 1'b1;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      byte_idx_q  <= 1'b0;
      shadow_q    <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      gap_err_q   <= 1'b0;
    end else begin
      rxs_prev_q  <= rxs;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_idx_q  <= byte_idx_d;
      shadow_q    <= shadow_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      gap_err_q   <= gap_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_cnt_d   = bit_cnt_q;
    byte_idx_d  = byte_idx_q;
    shadow_d    = shadow_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    gap_err_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (fall) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end

      ST_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (!rxs) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end else begin
            // Glitch: drop any half-filled word rather than resume mid-word.
            state_d    = ST_IDLE;
            byte_idx_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DATA: begin
        if (cnt_q == BIT_M1) begin
          cnt_d = '0;
          shadow_d[{byte_idx_q, bit_cnt_q}] = rxs;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_STOP: begin
        if (cnt_q == BIT_M1) begin
          cnt_d = '0;
          if (!rxs) begin
            frame_err_d = 1'b1;
            shadow_d    = '0;
            byte_idx_d  = 1'b0;
            state_d     = ST_IDLE;
          end else if (!byte_idx_q) begin
            byte_idx_d = 1'b1;
            state_d    = ST_GAP;
          end else begin
            rx_data_d  = shadow_q;
            rx_valid_d = 1'b1;
            byte_idx_d = 1'b0;
            state_d    = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_GAP: begin
        // A start edge on the timeout cycle still wins.
        if (fall) begin
          state_d = ST_START;
          cnt_d   = '0;
        end else if (cnt_q == GAP_M1) begin
          gap_err_d  = 1'b1;
          byte_idx_d = 1'b0;
          cnt_d      = '0;
          state_d    = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d    = ST_IDLE;
        byte_idx_d = 1'b0;
        cnt_d      = '0;
      end
    endcase
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign gap_err   = gap_err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx16.sv
module tb_uart_rx16;

  localparam int C  = 100;
  localparam int GB = 4;
  localparam int H  = C / 2;
  localparam int G  = GB * C;

  localparam int EV_VALID = 1;
  localparam int EV_FERR  = 2;
  localparam int EV_GERR  = 3;

  typedef struct {
    int         t;
    logic [7:0] b;
    bit         ok;
  } item_t;

  typedef struct {
    int          t;
    int          kind;
    logic [15:0] d;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_in = 1'b1;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        frame_err;
  logic        gap_err;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_valid  = 0;
  int n_ferr   = 0;
  int n_gerr   = 0;

  item_t       plan_q[$];
  ev_t         exp_q[$];
  int          cursor;
  logic [15:0] exp_data = 16'h0;

  uart_rx16 #(.CLKS_PER_BIT(C), .GAP_BITS(GB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_in     (rx_in),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .gap_err   (gap_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: each byte 0 waits for a byte 1 whose start edge is seen by the
  // receiver no later than the gap deadline; stop bits are judged mid-bit.
  // Edge reaches rxs 2 cycles after drive, one more cycle to recognise it,
  // then half a bit to mid start and 9 full bits to mid stop; pulses appear
  // one cycle after the deciding sample.
  task automatic push_ev(input int t, input int k, input logic [15:0] d);
    ev_t e;
    e.t = t; e.kind = k; e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic run_model();
    bit         pend;
    logic [7:0] pb;
    int         ps;
    int         s;
    pend = 0; pb = 8'h0; ps = 0;
    foreach (plan_q[i]) begin
      if (pend && (plan_q[i].t + 3 > ps + G)) begin
        push_ev(ps + G, EV_GERR, 16'h0);
        pend = 0;
      end
      s = plan_q[i].t + 3 + H + 9 * C;
      if (!plan_q[i].ok) begin
        push_ev(s, EV_FERR, 16'h0);
        pend = 0;
      end else if (!pend) begin
        pend = 1; pb = plan_q[i].b; ps = s;
      end else begin
        push_ev(s, EV_VALID, {plan_q[i].b, pb});
        pend = 0;
      end
    end
    if (pend) push_ev(ps + G, EV_GERR, 16'h0);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit ok);
    rx_in = 1'b0;
    repeat (C) tick();
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      repeat (C) tick();
    end
    rx_in = ok;
    repeat (C) tick();
    rx_in = 1'b1;
  endtask

  task automatic plan_begin();
    plan_q.delete();
    cursor = cyc + 20;
  endtask

  task automatic plan_frame(input logic [7:0] b, input bit ok, input int idle);
    item_t it;
    it.t = cursor + idle; it.b = b; it.ok = ok;
    plan_q.push_back(it);
    cursor = it.t + 10 * C;
  endtask

  task automatic run_plan();
    int last_t;
    run_model();
    last_t = (exp_q.size() > 0) ? exp_q[$].t : cursor;
    foreach (plan_q[i]) begin
      while (cyc < plan_q[i].t) tick();
      send_frame(plan_q[i].b, plan_q[i].ok);
    end
    while (exp_q.size() > 0 && cyc < last_t + 20) tick();
    repeat (5) tick();
    chk("missing_events", exp_q.size(), 0);
    exp_q.delete();
    chk("busy_after_plan", {31'h0, busy}, 32'h0);
  endtask

  // Compare process: every pulse must match the next predicted event in kind
  // and cycle; rx_data must always equal the last predicted word.
  always @(negedge clk) begin
    int  npulse;
    int  kind;
    ev_t e;
    if (!rst) begin
      exp_data = 16'h0;
      chk("reset_outputs", 32'({rx_data, rx_valid, frame_err, gap_err, busy}), 32'h0);
    end else begin
      npulse = int'(rx_valid) + int'(frame_err) + int'(gap_err);
      if (npulse > 1) begin
        chk("pulse_exclusive", npulse, 1);
      end else if (npulse == 1) begin
        kind = rx_valid ? EV_VALID : (frame_err ? EV_FERR : EV_GERR);
        if (kind == EV_VALID) n_valid++;
        if (kind == EV_FERR)  n_ferr++;
        if (kind == EV_GERR)  n_gerr++;
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", kind, 0);
        end else begin
          e = exp_q.pop_front();
          chk("event_kind", kind, e.kind);
          chk("event_cycle", cyc, e.t);
          if (e.kind == EV_VALID) exp_data = e.d;
        end
      end
      chk("rx_data", {16'h0, rx_data}, {16'h0, exp_data});
    end
  end

  initial begin
    repeat (150000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         v0, f0, g0;
    logic [7:0] b;
    bit         prev_ok, ok;
    int         idle, r;

    rst = 1'b0;
    rx_in = 1'b1;
    repeat (5) tick();
    chk("reset_rx_data_lit", {16'h0, rx_data}, 32'h0);
    chk("reset_busy_lit", {31'h0, busy}, 32'h0);
    rst = 1'b1;
    repeat (10) tick();

    // Word A534 with a two-bit-period gap between bytes.
    v0 = n_valid;
    plan_begin();
    plan_frame(8'h34, 1, 0);
    plan_frame(8'hA5, 1, 2 * C);
    run_plan();
    chk("a534_word_lit", {16'h0, rx_data}, 32'h0000A534);
    chk("a534_count_lit", n_valid - v0, 1);

    // Short low glitch on an idle line.
    v0 = n_valid + n_ferr + n_gerr;
    rx_in = 1'b0;
    repeat (20) tick();
    chk("glitch_busy_high", {31'h0, busy}, 32'h1);
    rx_in = 1'b1;
    repeat (60) tick();
    chk("glitch_busy_low", {31'h0, busy}, 32'h0);
    chk("glitch_data_lit", {16'h0, rx_data}, 32'h0000A534);
    chk("glitch_no_pulse", n_valid + n_ferr + n_gerr - v0, 0);

    // Frame error on byte 0, then a good word.
    v0 = n_valid; f0 = n_ferr;
    plan_begin();
    plan_frame(8'h55, 0, 0);
    plan_frame(8'h34, 1, C);
    plan_frame(8'h12, 1, 0);
    run_plan();
    chk("ferr_count_lit", n_ferr - f0, 1);
    chk("ferr_valid_lit", n_valid - v0, 1);
    chk("ferr_word_lit", {16'h0, rx_data}, 32'h00001234);

    // Gap timeout after a lone byte, then BEEF.
    v0 = n_valid; g0 = n_gerr;
    plan_begin();
    plan_frame(8'h7E, 1, 0);
    plan_frame(8'hEF, 1, 5 * C);
    plan_frame(8'hBE, 1, 0);
    run_plan();
    chk("gerr_count_lit", n_gerr - g0, 1);
    chk("gerr_word_lit", {16'h0, rx_data}, 32'h0000BEEF);

    // Byte 1 start edge landing exactly on the gap deadline, then one past.
    v0 = n_valid; g0 = n_gerr;
    plan_begin();
    plan_frame(8'h11, 1, 0);
    plan_frame(8'h22, 1, H - C + G);
    plan_frame(8'h33, 1, 2 * C);
    plan_frame(8'h44, 1, H - C + G + 1);
    plan_frame(8'h55, 1, 0);
    run_plan();
    chk("boundary_valid_lit", n_valid - v0, 2);
    chk("boundary_gerr_lit", n_gerr - g0, 1);
    chk("boundary_word_lit", {16'h0, rx_data}, 32'h00005544);

    // Back-to-back words with no idle time.
    v0 = n_valid;
    plan_begin();
    plan_frame(8'h01, 1, 0);
    plan_frame(8'h00, 1, 0);
    plan_frame(8'h00, 1, 0);
    plan_frame(8'h80, 1, 0);
    run_plan();
    chk("b2b_count_lit", n_valid - v0, 2);
    chk("b2b_word_lit", {16'h0, rx_data}, 32'h00008000);

    // Reset in the middle of byte 1 data.
    v0 = n_valid + n_ferr + n_gerr;
    repeat (20) tick();
    send_frame(8'h11, 1);
    rx_in = 1'b0;
    repeat (C) tick();
    b = 8'h22;
    for (int i = 0; i < 3; i++) begin
      rx_in = b[i];
      repeat (C) tick();
    end
    rst = 1'b0;
    rx_in = 1'b1;
    repeat (10) tick();
    chk("midreset_data_lit", {16'h0, rx_data}, 32'h0);
    chk("midreset_busy_lit", {31'h0, busy}, 32'h0);
    rst = 1'b1;
    repeat (2 * C) tick();
    chk("midreset_no_pulse", n_valid + n_ferr + n_gerr - v0, 0);
    v0 = n_valid;
    plan_begin();
    plan_frame(8'hFF, 1, 0);
    plan_frame(8'h00, 1, 0);
    run_plan();
    chk("postreset_word_lit", {16'h0, rx_data}, 32'h000000FF);
    chk("postreset_count_lit", n_valid - v0, 1);

    // Randomized traffic: mixed gaps, late byte 1, occasional bad stop bits.
    plan_begin();
    prev_ok = 1;
    for (int w = 0; w < 8; w++) begin
      for (int k = 0; k < 2; k++) begin
        ok = ($urandom_range(0, 7) != 0);
        if (k == 0) begin
          idle = $urandom_range(0, 2 * C);
        end else begin
          r = $urandom_range(0, 9);
          idle = (r < 3) ? 0 : (r < 8) ? $urandom_range(1, H - C + G)
                                       : $urandom_range(H - C + G + 1, 600);
        end
        if (!prev_ok) idle = idle + C;
        plan_frame(8'($urandom), ok, idle);
        prev_ok = ok;
      end
    end
    run_plan();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
